// File: rtl/axi_sram_write_slave.sv
// AXI4 write-channel slave for a single SRAM port: one outstanding burst,
// word writes driven combinationally during each W handshake.
module axi_sram_write_slave #(
   parameter int ADDR_WIDTH = 14,
   parameter int ID_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   AWID_S,
   input  logic [31:0]           AWADDR,
   input  logic [3:0]            AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [31:0]           WDATA,
   input  logic [3:0]            WSTRB,
   input  logic                  WLAST,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [ID_WIDTH-1:0]   BID_S,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wstrb
);

   // state  | meaning
   // IDLE   | waiting for a write address
   // DATA   | absorbing write beats into the SRAM
   // RESP   | presenting the write response until BREADY
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]            state;
   logic [ID_WIDTH-1:0]   bid;
   logic [ADDR_WIDTH-1:0] addr;
   logic [3:0]            len;
   logic [3:0]            count;
   logic                  fixed;
   logic                  err;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{AWADDR[31:ADDR_WIDTH+2], AWADDR[1:0]};

   assign AWREADY = (state == S_IDLE);
   assign WREADY  = (state == S_DATA);
   assign BVALID  = (state == S_RESP);
   assign BID_S   = bid;
   assign BRESP   = (BVALID && err) ? 2'b10 : 2'b00;

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;
   assign b_hs  = BVALID & BREADY;

   // Beats past the announced length, or any beat of an illegal burst, are swallowed.
   assign mem_we    = w_hs & ~err & (count <= len);
   assign mem_addr  = w_hs ? addr  : '0;
   assign mem_wdata = w_hs ? WDATA : '0;
   assign mem_wstrb = w_hs ? WSTRB : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         bid   <= '0;
         addr  <= '0;
         len   <= '0;
         count <= '0;
         fixed <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (aw_hs) begin
                  bid   <= AWID_S;
                  addr  <= AWADDR[ADDR_WIDTH+1:2];
                  len   <= AWLEN;
                  fixed <= (AWBURST == 2'b00);
                  count <= '0;
                  err   <= (AWBURST == 2'b11) | (AWSIZE > 3'b010);
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_hs) begin
                  if (!fixed)
                     addr <= addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                  if (count != 4'hF)
                     count <= count + 4'd1;
                  if (WLAST) begin
                     err   <= err | (count != len);
                     state <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (b_hs)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Directed bench for axi_sram_write_slave: inputs change 1 ns after the rising
// edge, outputs are read 2 ns after it.
module tb_axi_sram_write_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  AWID_S;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [7:0]  BID_S;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   int checks = 0;
   int errors = 0;
   int spurious = 0;
   logic [13:0] wa[$];
   logic [31:0] wd[$];
   logic [3:0]  ws[$];

   axi_sram_write_slave #(.ADDR_WIDTH(14), .ID_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .AWID_S(AWID_S), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID_S(BID_S), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   task automatic clear_log();
      wa.delete(); wd.delete(); ws.delete();
      spurious = 0;
   endtask

   task automatic sample_mem();
      if (mem_we) begin
         wa.push_back(mem_addr); wd.push_back(mem_wdata); ws.push_back(mem_wstrb);
         if (!(WVALID && WREADY)) spurious++;
      end
   endtask

   task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      AWID_S = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      #1;
      while (!AWREADY && n < 50) begin @(posedge clk); #2; n++; end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL aw_timeout: AWREADY got %b required 1", AWREADY);
      end
      @(posedge clk); #1;
      AWVALID = 1'b0;
   endtask

   task automatic send_beats(input int nbeats, input int last_idx, input logic [31:0] base,
                             input logic [3:0] strb, input logic [7:0] pattern);
      int beat = 0;
      int slot = 0;
      while (beat < nbeats && slot < 60) begin
         WVALID = pattern[slot % 8];
         WDATA  = base + beat;
         WSTRB  = strb;
         WLAST  = (beat == last_idx);
         #1;
         sample_mem();
         if (WVALID && WREADY) beat++;
         slot++;
         @(posedge clk); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
      if (beat < nbeats) begin
         checks++; errors++;
         $display("FAIL w_timeout: beats accepted %0d required %0d", beat, nbeats);
      end
   endtask

   task automatic get_resp(output logic [7:0] id, output logic [1:0] resp);
      int n = 0;
      #1;
      while (!BVALID && n < 50) begin @(posedge clk); #2; n++; end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL b_timeout: BVALID got %b required 1", BVALID);
      end
      id = BID_S; resp = BRESP;
      BREADY = 1'b1;
      @(posedge clk); #1;
      BREADY = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      AWVALID = 1'b0; AWID_S = 8'hFF; AWADDR = 32'hFFFF; AWLEN = 4'hF; AWSIZE = 3'b010; AWBURST = 2'b01;
      WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1'b1; BREADY = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++; if (AWREADY !== 1'b1) begin errors++; $display("FAIL rst_awready got %b required 1", AWREADY); end
      checks++; if (WREADY !== 1'b0) begin errors++; $display("FAIL rst_wready got %b required 0", WREADY); end
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b required 0", BVALID); end
      checks++; if (BID_S !== 8'h00) begin errors++; $display("FAIL rst_bid got %h required 00", BID_S); end
      checks++; if (BRESP !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b required 00", BRESP); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b required 0", mem_we); end
      checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL rst_mem_addr got %h required 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h required 0", mem_wdata); end
      checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL rst_mem_wstrb got %h required 0", mem_wstrb); end
      @(posedge clk); #1;
      rst = 1'b1; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
      @(posedge clk); #1;
      // WVALID in IDLE must not be taken
      WVALID = 1'b1;
      #1;
      checks++; if (WREADY !== 1'b0 || mem_we !== 1'b0) begin
         errors++; $display("FAIL idle_wvalid wready/mem_we got %b/%b required 0/0", WREADY, mem_we);
      end
      @(posedge clk); #1;
      WVALID = 1'b0;
   endtask

   task automatic test_single_beat();
      logic [7:0] id;
      logic [1:0] resp;
      clear_log();
      send_aw(8'h23, 32'h100, 4'd0, 3'b010, 2'b01);
      #1;
      checks++; if (WREADY !== 1'b1) begin errors++; $display("FAIL single_wready_t1 got %b required 1", WREADY); end
      send_beats(1, 0, 32'hDEADBEEF, 4'hF, 8'hFF);
      #1;
      checks++; if (BVALID !== 1'b1) begin errors++; $display("FAIL single_bvalid_l1 got %b required 1", BVALID); end
      get_resp(id, resp);
      checks++; if (id !== 8'h23) begin errors++; $display("FAIL single_bid got %h required 23", id); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp got %b required 00", resp); end
      checks++; if (wa.size() != 1) begin errors++; $display("FAIL single_nwrites got %0d required 1", wa.size()); end
      else if (wa[0] !== 14'h040 || wd[0] !== 32'hDEADBEEF || ws[0] !== 4'hF) begin
         errors++; $display("FAIL single_write got %h/%h/%h required 040/deadbeef/f", wa[0], wd[0], ws[0]);
      end
      #1;
      checks++; if (AWREADY !== 1'b1) begin errors++; $display("FAIL single_turnaround AWREADY got %b required 1", AWREADY); end
   endtask

   task automatic test_incr_burst();
      logic [7:0] id;
      logic [1:0] resp;
      clear_log();
      send_aw(8'h41, 32'h0, 4'd3, 3'b010, 2'b01);
      send_beats(4, 3, 32'h1000_0000, 4'h5, 8'hED);
      get_resp(id, resp);
      checks++; if (wa.size() != 4) begin errors++; $display("FAIL incr_nwrites got %0d required 4", wa.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++;
         if (wa[i] !== 14'(i) || wd[i] !== 32'h1000_0000 + i || ws[i] !== 4'h5) begin
            errors++; $display("FAIL incr_write%0d got %h/%h/%h required %h/%h/5", i, wa[i], wd[i], ws[i], i, 32'h1000_0000 + i);
         end
      end
      checks++; if (spurious != 0) begin errors++; $display("FAIL incr_spurious got %0d required 0", spurious); end
      checks++; if (id !== 8'h41 || resp !== 2'b00) begin errors++; $display("FAIL incr_resp got %h/%b required 41/00", id, resp); end
   endtask

   task automatic test_fixed_wrap();
      logic [7:0] id;
      logic [1:0] resp;
      clear_log();
      send_aw(8'h12, 32'h20, 4'd2, 3'b010, 2'b00);
      send_beats(3, 2, 32'hA000_0000, 4'hF, 8'hFF);
      get_resp(id, resp);
      checks++; if (wa.size() != 3) begin errors++; $display("FAIL fixed_nwrites got %0d required 3", wa.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (wa[i] !== 14'h008) begin errors++; $display("FAIL fixed_addr%0d got %h required 008", i, wa[i]); end
      end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got %b required 00", resp); end
      clear_log();
      send_aw(8'h13, 32'hFFFC, 4'd1, 3'b010, 2'b01);
      send_beats(2, 1, 32'hB000_0000, 4'hF, 8'hFF);
      get_resp(id, resp);
      checks++; if (wa.size() != 2) begin errors++; $display("FAIL wrap_nwrites got %0d required 2", wa.size()); end
      else if (wa[0] !== 14'h3FFF || wa[1] !== 14'h0000) begin
         errors++; $display("FAIL wrap_addr got %h,%h required 3fff,0000", wa[0], wa[1]);
      end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp got %b required 00", resp); end
   endtask

   task automatic test_len_mismatch();
      logic [7:0] id;
      logic [1:0] resp;
      clear_log();
      send_aw(8'h31, 32'h200, 4'd3, 3'b010, 2'b01);
      send_beats(2, 1, 32'hC000_0000, 4'hF, 8'hFF);
      get_resp(id, resp);
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL short_bresp got %b required 10", resp); end
      checks++; if (wa.size() != 2) begin errors++; $display("FAIL short_nwrites got %0d required 2", wa.size()); end
      clear_log();
      send_aw(8'h32, 32'h80, 4'd0, 3'b010, 2'b01);
      send_beats(3, 2, 32'hD000_0000, 4'hF, 8'hFF);
      get_resp(id, resp);
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL long_bresp got %b required 10", resp); end
      checks++; if (wa.size() != 1) begin errors++; $display("FAIL long_nwrites got %0d required 1", wa.size()); end
      else if (wa[0] !== 14'h020 || wd[0] !== 32'hD000_0000) begin
         errors++; $display("FAIL long_write got %h/%h required 020/d0000000", wa[0], wd[0]);
      end
   endtask

   task automatic test_illegal();
      logic [7:0] id;
      logic [1:0] resp;
      clear_log();
      send_aw(8'h44, 32'h300, 4'd1, 3'b011, 2'b01);
      send_beats(2, 1, 32'hE000_0000, 4'hF, 8'hFF);
      get_resp(id, resp);
      checks++; if (wa.size() != 0) begin errors++; $display("FAIL size_nwrites got %0d required 0", wa.size()); end
      checks++; if (resp !== 2'b10 || id !== 8'h44) begin errors++; $display("FAIL size_resp got %h/%b required 44/10", id, resp); end
      clear_log();
      send_aw(8'h45, 32'h300, 4'd2, 3'b010, 2'b11);
      send_beats(3, 2, 32'hF000_0000, 4'hF, 8'hFF);
      get_resp(id, resp);
      checks++; if (wa.size() != 0) begin errors++; $display("FAIL burst_nwrites got %0d required 0", wa.size()); end
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL burst_bresp got %b required 10", resp); end
   endtask

   task automatic test_backpressure_reset();
      logic [7:0] id;
      logic [1:0] resp;
      int n = 0;
      clear_log();
      send_aw(8'h7A, 32'h0, 4'd0, 3'b011, 2'b01);
      send_beats(1, 0, 32'h1234_5678, 4'hF, 8'hFF);
      #1;
      while (!BVALID && n < 50) begin @(posedge clk); #2; n++; end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (BVALID !== 1'b1 || BID_S !== 8'h7A || BRESP !== 2'b10) begin
            errors++; $display("FAIL bp_hold%0d got %b/%h/%b required 1/7a/10", i, BVALID, BID_S, BRESP);
         end
         @(posedge clk); #2;
      end
      BREADY = 1'b1;
      @(posedge clk); #1;
      BREADY = 1'b0;
      #1;
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL bp_release BVALID got %b required 0", BVALID); end

      clear_log();
      send_aw(8'h66, 32'h400, 4'd3, 3'b010, 2'b01);
      send_beats(2, 99, 32'h5500_0000, 4'hF, 8'hFF);
      checks++; if (wa.size() != 2) begin errors++; $display("FAIL rstmid_pre_nwrites got %0d required 2", wa.size()); end
      WVALID = 1'b1; WDATA = 32'h9999_9999;
      rst = 1'b0;
      #1;
      checks++;
      if (AWREADY !== 1'b1 || WREADY !== 1'b0 || BVALID !== 1'b0 || BID_S !== 8'h00 || BRESP !== 2'b00) begin
         errors++; $display("FAIL rstmid_ctrl got aw%b w%b b%b id%h r%b required 1/0/0/00/00", AWREADY, WREADY, BVALID, BID_S, BRESP);
      end
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 14'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
         errors++; $display("FAIL rstmid_mem got %b/%h/%h/%h required 0/0/0/0", mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      @(posedge clk); #1;
      rst = 1'b1; WVALID = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL rstmid_no_resp BVALID got %b required 0", BVALID); end
      @(posedge clk); #1;
      clear_log();
      send_aw(8'h5C, 32'h40, 4'd0, 3'b010, 2'b01);
      send_beats(1, 0, 32'h0BAD_F00D, 4'h3, 8'hFF);
      get_resp(id, resp);
      checks++; if (id !== 8'h5C || resp !== 2'b00) begin errors++; $display("FAIL post_rst_resp got %h/%b required 5c/00", id, resp); end
      checks++; if (wa.size() != 1) begin errors++; $display("FAIL post_rst_nwrites got %0d required 1", wa.size()); end
      else if (wa[0] !== 14'h010 || wd[0] !== 32'h0BAD_F00D || ws[0] !== 4'h3) begin
         errors++; $display("FAIL post_rst_write got %h/%h/%h required 010/0badf00d/3", wa[0], wd[0], ws[0]);
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_incr_burst();
      test_fixed_wrap();
      test_len_mismatch();
      test_illegal();
      test_backpressure_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
